// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timer_counter
//  Description : Bus-mapped 32-bit down-counting timer with one-shot (sticky
//                interrupt) and auto-reload (one-cycle pulse) modes.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    localparam logic [1:0] c_REG_CTRL   = 2'd0;
    localparam logic [1:0] c_REG_PRESET = 2'd1;
    localparam logic [1:0] c_REG_COUNT  = 2'd2;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;      // {IM, Mode[1:0], Enable}
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic [1:0]  w_sel;
    logic        w_unused_bits;

    assign w_sel         = Addr[3:2];
    assign w_unused_bits = ^{Addr[31:4], Addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_q[0]) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d    = preset_q;
                irq_flag_d = 1'b0;
                state_d    = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                if (ctrl_q[2:1] == 2'b00) begin
                    ctrl_d[0] = 1'b0;
                end else begin
                    irq_flag_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus writes come last so they override the hardware Enable clear.
        if (WE) begin
            if (w_sel == c_REG_CTRL) begin
                ctrl_d     = Din[3:0];
                irq_flag_d = 1'b0;
            end else if (w_sel == c_REG_PRESET) begin
                preset_d   = Din;
                irq_flag_d = 1'b0;
            end
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (w_sel)
            c_REG_CTRL:   Dout = {28'd0, ctrl_q};
            c_REG_PRESET: Dout = preset_q;
            c_REG_COUNT:  Dout = count_q;
            default:      Dout = 32'd0;
        endcase
    end

    assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_counter
//  Description : Directed and randomized checks of timer_counter against a
//                phase-based timing model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int tests;
    int fails;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    task automatic do_reset();
        logic [31:0] d;
        reset = 1'b1;
        WE    = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(32'(i * 4), d);
            chk("reset_read", d, 32'd0);
        end
        chk("reset_irq", {31'd0, IRQ}, 32'd0);
    endtask

    // Expected behaviour as a function of p = edges since the Enable write.
    // A PRESET of 0 times out like a PRESET of 1.
    task automatic run_case(input int P, input int mode, input int im, input int ncyc);
        logic [31:0] d;
        logic [31:0] ec;
        logic [31:0] cv;
        logic        ef;
        logic        een;
        int          pp;
        int          len;
        int          q;
        do_reset();
        wr(32'd4, 32'(P));
        rd(32'd8, d);
        chk("count_after_preset", d, 32'd0);
        cv = {28'd0, im[0], mode[1:0], 1'b1};
        wr(32'd0, cv);
        pp  = (P == 0) ? 1 : P;
        len = pp + 3;
        for (int p = 0; p < ncyc; p++) begin
            if (mode == 0) begin
                if (p <= 1)           ec = 32'd0;
                else if (p <= pp + 1) ec = 32'(P - (p - 2));
                else                  ec = 32'd0;
                ef  = (p >= pp + 2);
                een = (p < pp + 3);
            end else begin
                q = (p <= 1) ? p : ((p - 1) % len) + 1;
                if (q <= 1)           ec = 32'd0;
                else if (q <= pp + 1) ec = 32'(P - (q - 2));
                else                  ec = 32'd0;
                ef  = (q == pp + 2);
                een = 1'b1;
            end
            rd(32'd8, d);
            chk("count", d, ec);
            chk("irq", {31'd0, IRQ}, {31'd0, im[0] & ef});
            rd(32'd0, d);
            chk("ctrl", d, {28'd0, im[0], mode[1:0], een});
            tick();
        end
    endtask

    initial begin
        logic [31:0] d;
        int          rp;
        int          rm;
        int          ri;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        WE    = 1'b0;
        Addr  = 32'd0;
        Din   = 32'd0;
        tick();

        do_reset();
        wr(32'd8, 32'hDEAD_BEEF);
        wr(32'd12, 32'h1234_5678);
        rd(32'd8, d);
        chk("count_write_ignored", d, 32'd0);
        rd(32'd12, d);
        chk("reserved_read", d, 32'd0);

        // One-shot, P=5: sticky IRQ, then a CTRL write clears it.
        run_case(5, 0, 1, 14);
        wr(32'd0, 32'h8);
        chk("oneshot_irq_clear", {31'd0, IRQ}, 32'd0);
        rd(32'd0, d);
        chk("oneshot_ctrl_after_clear", d, 32'h8);

        run_case(2, 1, 1, 20);
        run_case(0, 0, 1, 8);
        run_case(3, 0, 0, 10);
        run_case(1, 3, 1, 14);

        for (int n = 0; n < 8; n++) begin
            rp = $urandom_range(0, 10);
            rm = $urandom_range(0, 3);
            ri = $urandom_range(0, 1);
            run_case(rp, rm, ri, 2 * (rp + 4) + $urandom_range(0, 6));
        end

        // Disable mid-count: the write edge still decrements, then COUNT freezes.
        do_reset();
        wr(32'd4, 32'd100);
        wr(32'd0, 32'h9);
        for (int i = 0; i < 20; i++) tick();
        rd(32'd8, d);
        chk("midcount_value", d, 32'd82);
        wr(32'd0, 32'h8);
        for (int i = 0; i < 5; i++) begin
            rd(32'd8, d);
            chk("freeze_count", d, 32'd81);
            chk("freeze_irq", {31'd0, IRQ}, 32'd0);
            tick();
        end

        // Reset during CNT aborts everything.
        wr(32'd0, 32'h9);
        for (int i = 0; i < 6; i++) tick();
        rd(32'd8, d);
        chk("count_before_abort", d, 32'd96);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
